// File: rtl/spi_regfile_pkg.sv
// Shared types and sizing helpers for the SPI register-file peripheral.
// Provides the FSM state enum, frame/counter width helpers and the R/W code.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic RW_WRITE = 1'b1;

    function automatic int frame_w(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

    // Must hold FRAME_W+1, the overlength marker.
    function automatic int cnt_w(input int aw, input int dw);
        return $clog2(frame_w(aw, dw) + 2);
    endfunction

    localparam int CNT_W_DEF = cnt_w(7, 8);

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with rise/fall pulses on the synchronised level.
// Ports: clk, rst_n, din (async in), dout (sync level), rise, fall.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [STAGES:0]   fill_q, fill_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
        fill_d = {fill_q[STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            fill_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            fill_q <= fill_d;
        end
    end

    // Edges are masked until the chain holds real samples, so a level
    // already present at reset release is not mistaken for an edge.
    assign dout = sync_q[STAGES-1];
    assign rise = fill_q[STAGES] & dout & ~prev_q;
    assign fall = fill_q[STAGES] & ~dout & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral giving read/write access to a small register file.
// Ports: clk, rst_n, sclk_in, ncs_in, copi_in, cipo_out, cipo_oe,
//        regs_flat, wr_strobe, wr_addr, frame_err.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk_in,
    input  logic                       ncs_in,
    input  logic                       copi_in,
    output logic                       cipo_out,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = cnt_w(ADDR_W, DATA_W);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  CNT_ADDR = CNT_W'(ADDR_W);
    localparam logic [ADDR_W:0]   NREGS    = (ADDR_W+1)'(NUM_REGS);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic ncs_sync, ncs_start, ncs_end;
    logic copi_sync;

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk_in),
        .dout  (sclk_lvl_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_ncs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ncs_in),
        .dout  (ncs_sync),
        .rise  (ncs_end),
        .fall  (ncs_start)
    );

    logic [SYNC_STAGES-1:0] copi_q, copi_d;

    assign copi_d    = {copi_q[SYNC_STAGES-2:0], copi_in};
    assign copi_sync = copi_q[SYNC_STAGES-1];

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         rw_q, rw_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [DATA_W-1:0]            data_q, data_d;
    logic [DATA_W-1:0]            shout_q, shout_d;
    logic                         loaded_q, loaded_d;
    logic                         cipo_q, cipo_d;
    logic [NUM_REGS*DATA_W-1:0]   regs_q, regs_d;
    logic                         wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]            wr_addr_q, wr_addr_d;
    logic                         frame_err_q, frame_err_d;

    logic [DATA_W-1:0] rd_data;
    logic              bad_frame;

    // Out-of-range addresses read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                rd_data = regs_q[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bad_frame = (cnt_q != CNT_FULL) || ({1'b0, addr_q} >= NREGS);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        shout_d     = shout_q;
        loaded_d    = loaded_q;
        cipo_d      = cipo_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;

        if (ncs_sync) begin
            cnt_d    = '0;
            loaded_d = 1'b0;
            cipo_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (ncs_start) begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
            end
            CMD: begin
                if (ncs_end) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        rw_d = copi_sync;
                    end else begin
                        addr_d = ADDR_W'({addr_q, copi_sync});
                    end
                    if (cnt_q == CNT_ADDR) begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (ncs_end) begin
                    state_d = IDLE;
                    if (bad_frame) begin
                        frame_err_d = 1'b1;
                    end else if (rw_q == RW_WRITE) begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_q == ADDR_W'(i)) begin
                                regs_d[i*DATA_W +: DATA_W] = data_q;
                            end
                        end
                    end
                end else begin
                    if (sclk_rise) begin
                        if (cnt_q != CNT_SAT) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        data_d = DATA_W'({data_q, copi_sync});
                    end
                    // First fall in DATA loads the word; later falls shift.
                    if (sclk_fall && rw_q != RW_WRITE) begin
                        if (!loaded_q) begin
                            loaded_d = 1'b1;
                            cipo_d   = rd_data[DATA_W-1];
                            shout_d  = rd_data << 1;
                        end else begin
                            cipo_d  = shout_q[DATA_W-1];
                            shout_d = shout_q << 1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copi_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            shout_q     <= '0;
            loaded_q    <= 1'b0;
            cipo_q      <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            copi_q      <= copi_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            shout_q     <= shout_d;
            loaded_q    <= loaded_d;
            cipo_q      <= cipo_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cipo_out  = cipo_q;
    assign cipo_oe   = ~ncs_sync;
    assign regs_flat = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench for spi_regfile_peripheral (default parameters).
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_spi_regfile_peripheral;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk_in;
    logic        ncs_in;
    logic        copi_in;
    logic        cipo_out;
    logic        cipo_oe;
    logic [39:0] regs_flat;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        err;
        logic [6:0]  addr;
        logic [39:0] regs;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] rd_act_q[$];
    logic [7:0] m [5];

    always #5 clk = ~clk;

    spi_regfile_peripheral dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk_in   (sclk_in),
        .ncs_in    (ncs_in),
        .copi_in   (copi_in),
        .cipo_out  (cipo_out),
        .cipo_oe   (cipo_oe),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    function automatic logic [39:0] model_flat();
        logic [39:0] f;
        for (int i = 0; i < 5; i++) f[i*8 +: 8] = m[i];
        return f;
    endfunction

    // Monitor: every strobe/error pulse and every captured read word
    // must match the next expected entry.
    always @(negedge clk) begin
        ev_t e;
        if (wr_strobe || frame_err) begin
            checks++;
            if (ev_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event strobe=%0b err=%0b addr=%0d",
                         wr_strobe, frame_err, wr_addr);
            end else begin
                e = ev_q.pop_front();
                if (frame_err !== e.err || wr_strobe !== ~e.err ||
                    (!e.err && wr_addr !== e.addr) || regs_flat !== e.regs) begin
                    errors++;
                    $display("FAIL event got strobe=%0b err=%0b addr=%0d regs=%h want err=%0b addr=%0d regs=%h",
                             wr_strobe, frame_err, wr_addr, regs_flat,
                             e.err, e.addr, e.regs);
                end
            end
        end
        if (rd_act_q.size() > 0) begin
            logic [7:0] a;
            logic [7:0] x;
            checks++;
            a = rd_act_q.pop_front();
            if (rd_exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected got=%h", a);
            end else begin
                x = rd_exp_q.pop_front();
                if (a !== x) begin
                    errors++;
                    $display("FAIL read_data got=%h want=%h", a, x);
                end
            end
        end
    end

    task automatic check_val(input string name, input logic [39:0] got,
                             input logic [39:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send_bits(input int hi, input int lo,
                             input logic [31:0] v, output logic [7:0] rd);
        rd = '0;
        for (int i = hi; i >= lo; i--) begin
            copi_in = v[i];
            repeat (HALF) @(negedge clk);
            rd = {rd[6:0], cipo_out};
            sclk_in = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk_in = 1'b0;
        end
    endtask

    task automatic frame(input int n, input logic [31:0] v, input int gap,
                         output logic [7:0] rd);
        ncs_in = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(n - 1, 0, v, rd);
        repeat (HALF) @(negedge clk);
        check_val("oe_in_frame", 40'(cipo_oe), 40'd1);
        ncs_in = 1'b1;
        repeat (gap) @(negedge clk);
        check_val("oe_after_frame", 40'(cipo_oe), 40'd0);
        check_val("cipo_after_frame", 40'(cipo_out), 40'd0);
    endtask

    task automatic push_wr(input int a, input logic [7:0] d);
        m[a] = d;
        ev_q.push_back(ev_t'{err: 1'b0, addr: 7'(a), regs: model_flat()});
    endtask

    task automatic push_err();
        ev_q.push_back(ev_t'{err: 1'b1, addr: 7'd0, regs: model_flat()});
    endtask

    task automatic write(input int a, input logic [7:0] d, input int gap);
        logic [7:0] r;
        frame(16, 32'({1'b1, 7'(a), d}), gap, r);
    endtask

    task automatic read(input int a, input logic [7:0] want);
        logic [7:0] r;
        rd_exp_q.push_back(want);
        frame(16, 32'({1'b0, 7'(a), 8'h00}), HALF, r);
        rd_act_q.push_back(r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  r;
        logic [31:0] v;
        rst_n   = 1'b0;
        sclk_in = 1'b0;
        ncs_in  = 1'b1;
        copi_in = 1'b0;
        for (int i = 0; i < 5; i++) m[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_regs", regs_flat, 40'h0);
        check_val("rst_cipo", 40'(cipo_out), 40'd0);
        check_val("rst_oe", 40'(cipo_oe), 40'd0);
        check_val("rst_strobe", 40'(wr_strobe), 40'd0);
        check_val("rst_err", 40'({wr_addr, frame_err}), 40'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        push_wr(2, 8'hA5);
        write(2, 8'hA5, HALF);

        push_wr(4, 8'h3C);
        write(4, 8'h3C, HALF);
        read(4, 8'h3C);
        check_val("regs_after_read", regs_flat, model_flat());

        push_err();
        write(5, 8'h99, HALF);
        push_err();
        read(5, 8'h00);

        v = 32'({1'b1, 7'd0, 8'hFF});
        push_err();
        frame(15, v >> 1, HALF, r);
        push_err();
        frame(17, v << 1, HALF, r);
        check_val("reg0_after_bad", 40'(regs_flat[7:0]), 40'h00);

        push_wr(0, 8'h11);
        write(0, 8'h11, 4);
        push_wr(1, 8'h22);
        write(1, 8'h22, HALF);

        push_wr(1, 8'h77);
        write(1, 8'h77, HALF);
        v = 32'({1'b1, 7'd3, 8'h11});
        ncs_in = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(15, 8, v, r);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) m[i] = 8'h00;
        check_val("midrst_regs", regs_flat, 40'h0);
        check_val("midrst_strobe", 40'({wr_strobe, frame_err}), 40'd0);
        check_val("midrst_addr", 40'(wr_addr), 40'd0);
        check_val("midrst_cipo", 40'({cipo_out, cipo_oe}), 40'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_bits(7, 0, v, r);
        repeat (HALF) @(negedge clk);
        ncs_in = 1'b1;
        repeat (HALF) @(negedge clk);

        push_wr(1, 8'h42);
        write(1, 8'h42, HALF);
        read(1, 8'h42);
        read(3, 8'h00);

        repeat (20) @(negedge clk);
        check_val("events_pending", 40'(ev_q.size()), 40'd0);
        check_val("reads_pending", 40'(rd_exp_q.size()), 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
